// File: rtl/sprite_pkg.sv
// Shared constants and pipeline types for the sprite fetch path.
// Imported by the address calculator and the arbiter top.
package sprite_pkg;

  localparam logic [18:0] SCREEN_W     = 19'd640;
  localparam logic [18:0] SPRITE_DIM   = 19'd30;
  localparam logic [18:0] SPRITE_WORDS = 19'd900;
  localparam logic [18:0] COLOR_STRIDE = 19'd3600;
  localparam logic [18:0] CRASH_BASE   = 19'd14400;
  localparam logic [2:0]  ORIENT_CRASH = 3'd5;

  typedef struct packed {
    logic valid;
    logic tag;
    logic hit;
  } stage_t;

endpackage

// File: rtl/sprite_addr_calc.sv
// Maps a screen pixel to a sprite-ROM word address.
// Purely combinational; rom_addr is 0 whenever the pixel misses.
module sprite_addr_calc
  import sprite_pkg::*;
(
  input  logic [18:0] addr,
  input  logic [18:0] start,
  input  logic [2:0]  orient,
  input  logic [2:0]  color,
  output logic [18:0] rom_addr,
  output logic        hit
);

  logic [18:0] off;
  logic [18:0] row;
  logic [18:0] col;
  logic [18:0] pix;
  logic [18:0] base;
  logic        orient_ok;

  always_comb begin
    // A pixel left of/above the corner wraps to a huge offset and misses.
    off       = addr - start;
    row       = off / SCREEN_W;
    col       = off % SCREEN_W;
    pix       = row * SPRITE_DIM + col;
    orient_ok = (orient <= 3'd3) || (orient == ORIENT_CRASH);
    hit       = orient_ok && (row < SPRITE_DIM) && (col < SPRITE_DIM);
    if (orient == ORIENT_CRASH) begin
      base = CRASH_BASE;
    end else begin
      base = 19'(orient) * SPRITE_WORDS
           + 19'(color) * COLOR_STRIDE;
    end
    rom_addr = hit ? (base + pix) : '0;
  end

endmodule

// File: rtl/sprite_fetch_arbiter.sv
// Round-robin arbiter for two sprite pixel requesters sharing one ROM.
// Fixed 3-cycle pipeline; misses ride along so responses stay ordered.
module sprite_fetch_arbiter
  import sprite_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        hold,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [18:0] req_addr0,
  input  logic [18:0] req_addr1,
  input  logic [18:0] req_start0,
  input  logic [18:0] req_start1,
  input  logic [2:0]  req_orient0,
  input  logic [2:0]  req_orient1,
  input  logic [2:0]  req_color0,
  input  logic [2:0]  req_color1,
  output logic        rom_en,
  output logic [18:0] rom_addr,
  input  logic [7:0]  rom_data,
  output logic [1:0]  rsp_valid,
  output logic [7:0]  rsp_data,
  output logic        rsp_hit
);

  logic        ptr_q, ptr_d;
  logic        gnt, gnt_id;
  stage_t      s1_q, s1_d;
  stage_t      s2_q, s2_d;
  logic        rom_en_q, rom_en_d;
  logic [18:0] rom_addr_q, rom_addr_d;
  logic [1:0]  rsp_valid_q, rsp_valid_d;
  logic [7:0]  rsp_data_q, rsp_data_d;
  logic        rsp_hit_q, rsp_hit_d;

  logic [18:0] sel_addr, sel_start;
  logic [2:0]  sel_orient, sel_color;
  logic [18:0] calc_addr;
  logic        calc_hit;

  always_comb begin
    req_ready = 2'b00;
    ptr_d     = ptr_q;
    if (!rst && !hold) begin
      unique case (req_valid)
        2'b01:   req_ready = 2'b01;
        2'b10:   req_ready = 2'b10;
        2'b11:   req_ready = ptr_q ? 2'b10 : 2'b01;
        default: req_ready = 2'b00;
      endcase
    end
    gnt    = |req_ready;
    gnt_id = req_ready[1];
    if (gnt) ptr_d = ~gnt_id;
  end

  assign sel_addr   = gnt_id ? req_addr1   : req_addr0;
  assign sel_start  = gnt_id ? req_start1  : req_start0;
  assign sel_orient = gnt_id ? req_orient1 : req_orient0;
  assign sel_color  = gnt_id ? req_color1  : req_color0;

  sprite_addr_calc u_calc (
    .addr     (sel_addr),
    .start    (sel_start),
    .orient   (sel_orient),
    .color    (sel_color),
    .rom_addr (calc_addr),
    .hit      (calc_hit)
  );

  always_comb begin
    s1_d.valid = gnt;
    s1_d.tag   = gnt_id;
    s1_d.hit   = gnt & calc_hit;
    rom_en_d   = gnt & calc_hit;
    rom_addr_d = rom_en_d ? calc_addr : '0;
    s2_d       = s1_q;
    rsp_valid_d = 2'b00;
    if (s2_q.valid) begin
      rsp_valid_d = s2_q.tag ? 2'b10 : 2'b01;
    end
    rsp_hit_d  = s2_q.valid & s2_q.hit;
    rsp_data_d = rsp_hit_d ? rom_data : 8'h00;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= 1'b0;
      s1_q        <= '0;
      s2_q        <= '0;
      rom_en_q    <= 1'b0;
      rom_addr_q  <= '0;
      rsp_valid_q <= 2'b00;
      rsp_data_q  <= 8'h00;
      rsp_hit_q   <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      rom_en_q    <= rom_en_d;
      rom_addr_q  <= rom_addr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_hit_q   <= rsp_hit_d;
    end
  end

  assign rom_en    = rom_en_q;
  assign rom_addr  = rom_addr_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_hit   = rsp_hit_q;

endmodule

// File: tb/tb_sprite_fetch_arbiter.sv
// Directed bench for sprite_fetch_arbiter with a registered ROM model.
// ROM word = low address byte ^ 8'h5A; idle ROM output is 8'hEE.
module tb_sprite_fetch_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        hold;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [18:0] req_addr0, req_addr1;
  logic [18:0] req_start0, req_start1;
  logic [2:0]  req_orient0, req_orient1;
  logic [2:0]  req_color0, req_color1;
  logic        rom_en;
  logic [18:0] rom_addr;
  logic [7:0]  rom_data = 8'hEE;
  logic [1:0]  rsp_valid;
  logic [7:0]  rsp_data;
  logic        rsp_hit;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  always @(posedge clk)
    rom_data <= rom_en ? (rom_addr[7:0] ^ 8'h5A) : 8'hEE;

  sprite_fetch_arbiter dut (
    .clk(clk), .rst(rst), .hold(hold),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr0(req_addr0), .req_addr1(req_addr1),
    .req_start0(req_start0), .req_start1(req_start1),
    .req_orient0(req_orient0), .req_orient1(req_orient1),
    .req_color0(req_color0), .req_color1(req_color1),
    .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_hit(rsp_hit)
  );

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = 2'b00;
    hold = 1'b0;
    next_cycle();
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    hold = 1'b0;
    req_valid = 2'b11;
    next_cycle();
    next_cycle();
    #1;
    total_cnt++;
    if (req_ready !== 2'b00)
      $display("FAIL reset_ready got %b want 00", req_ready);
    else pass_cnt++;
    total_cnt++;
    if (rom_en !== 1'b0 || rom_addr !== 19'd0)
      $display("FAIL reset_rom got en=%b addr=%0d want 0/0",
               rom_en, rom_addr);
    else pass_cnt++;
    total_cnt++;
    if (rsp_valid !== 2'b00 || rsp_data !== 8'h00 || rsp_hit !== 1'b0)
      $display("FAIL reset_rsp got v=%b d=%h h=%b want 00/00/0",
               rsp_valid, rsp_data, rsp_hit);
    else pass_cnt++;
    req_valid = 2'b00;
    rst = 1'b0;
    next_cycle();
  endtask

  task automatic run_single(input string nm, input bit p,
                            input logic [18:0] a, input logic [18:0] s,
                            input logic [2:0] o, input logic [2:0] c,
                            input bit eh, input logic [18:0] ea,
                            input logic [7:0] ed);
    logic [1:0] ev;
    ev = p ? 2'b10 : 2'b01;
    if (p) begin
      req_addr1 = a; req_start1 = s; req_orient1 = o; req_color1 = c;
    end else begin
      req_addr0 = a; req_start0 = s; req_orient0 = o; req_color0 = c;
    end
    req_valid = ev;
    #1;
    total_cnt++;
    if (req_ready !== ev)
      $display("FAIL %s_ready got %b want %b", nm, req_ready, ev);
    else pass_cnt++;
    next_cycle();
    req_valid = 2'b00;
    total_cnt++;
    if (rom_en !== eh || rom_addr !== ea)
      $display("FAIL %s_rom got en=%b addr=%0d want en=%b addr=%0d",
               nm, rom_en, rom_addr, eh, ea);
    else pass_cnt++;
    next_cycle();
    total_cnt++;
    if (rsp_valid !== 2'b00)
      $display("FAIL %s_early got %b want 00", nm, rsp_valid);
    else pass_cnt++;
    next_cycle();
    total_cnt++;
    if (rsp_valid !== ev || rsp_hit !== eh || rsp_data !== ed)
      $display("FAIL %s_rsp got v=%b h=%b d=%h want v=%b h=%b d=%h",
               nm, rsp_valid, rsp_hit, rsp_data, ev, eh, ed);
    else pass_cnt++;
    next_cycle();
    total_cnt++;
    if (rsp_valid !== 2'b00)
      $display("FAIL %s_pulse got %b want 00", nm, rsp_valid);
    else pass_cnt++;
  endtask

  task automatic test_p0_bike();
    run_single("p0_bike", 1'b0, 19'd2285, 19'd1000, 3'd1, 3'd2,
               1'b1, 19'd8165, 8'hBF);
  endtask

  task automatic test_p1_crash();
    run_single("p1_crash", 1'b1, 19'd1924, 19'd0, 3'd5, 3'd3,
               1'b1, 19'd14494, 8'hC4);
  endtask

  task automatic test_miss();
    run_single("miss_col30", 1'b0, 19'd1030, 19'd1000, 3'd1, 3'd0,
               1'b0, 19'd0, 8'h00);
    run_single("miss_neg", 1'b0, 19'd999, 19'd1000, 3'd1, 3'd0,
               1'b0, 19'd0, 8'h00);
    run_single("miss_orient4", 1'b1, 19'd2285, 19'd1000, 3'd4, 3'd0,
               1'b0, 19'd0, 8'h00);
  endtask

  task automatic test_corner_hit();
    // row 29, col 29 is the last pixel inside the sprite
    run_single("corner", 1'b1, 19'd19589, 19'd1000, 3'd0, 3'd0,
               1'b1, 19'd899, 8'hD9);
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_rdy [4];
    logic [1:0] exp_rv;
    exp_rdy[0] = 2'b01; exp_rdy[1] = 2'b10;
    exp_rdy[2] = 2'b01; exp_rdy[3] = 2'b10;
    do_reset();
    req_addr0 = 19'd2285; req_start0 = 19'd1000;
    req_orient0 = 3'd1; req_color0 = 3'd2;
    req_addr1 = 19'd1924; req_start1 = 19'd0;
    req_orient1 = 3'd5; req_color1 = 3'd0;
    for (int k = 0; k < 7; k++) begin
      req_valid = (k < 4) ? 2'b11 : 2'b00;
      #1;
      if (k < 4) begin
        total_cnt++;
        if (req_ready !== exp_rdy[k])
          $display("FAIL b2b_ready[%0d] got %b want %b",
                   k, req_ready, exp_rdy[k]);
        else pass_cnt++;
      end
      exp_rv = (k >= 3) ? exp_rdy[k-3] : 2'b00;
      total_cnt++;
      if (rsp_valid !== exp_rv)
        $display("FAIL b2b_rsp[%0d] got %b want %b", k, rsp_valid, exp_rv);
      else pass_cnt++;
      next_cycle();
    end
  endtask

  task automatic test_reset_flight();
    do_reset();
    req_addr0 = 19'd2285; req_start0 = 19'd1000;
    req_orient0 = 3'd1; req_color0 = 3'd2;
    req_valid = 2'b01;
    #1;
    total_cnt++;
    if (req_ready !== 2'b01)
      $display("FAIL flight_accept got %b want 01", req_ready);
    else pass_cnt++;
    next_cycle();
    rst = 1'b1;
    req_valid = 2'b11;
    #1;
    total_cnt++;
    if (req_ready !== 2'b00)
      $display("FAIL flight_rst_ready got %b want 00", req_ready);
    else pass_cnt++;
    next_cycle();
    rst = 1'b0;
    #1;
    total_cnt++;
    if (rom_en !== 1'b0 || rsp_valid !== 2'b00)
      $display("FAIL flight_drop got en=%b v=%b want 0/00",
               rom_en, rsp_valid);
    else pass_cnt++;
    total_cnt++;
    if (req_ready !== 2'b01)
      $display("FAIL flight_ptr got %b want 01", req_ready);
    else pass_cnt++;
    next_cycle();
    req_valid = 2'b00;
    for (int k = 3; k <= 4; k++) begin
      total_cnt++;
      if (rsp_valid !== 2'b00)
        $display("FAIL flight_quiet[N+%0d] got %b want 00", k, rsp_valid);
      else pass_cnt++;
      next_cycle();
    end
    total_cnt++;
    if (rsp_valid !== 2'b01)
      $display("FAIL flight_regrant got %b want 01", rsp_valid);
    else pass_cnt++;
    next_cycle();
  endtask

  task automatic test_hold();
    do_reset();
    req_valid = 2'b01;
    #1;
    total_cnt++;
    if (req_ready !== 2'b01)
      $display("FAIL hold_pre got %b want 01", req_ready);
    else pass_cnt++;
    next_cycle();
    hold = 1'b1;
    req_valid = 2'b11;
    for (int k = 0; k < 2; k++) begin
      #1;
      total_cnt++;
      if (req_ready !== 2'b00)
        $display("FAIL hold_block[%0d] got %b want 00", k, req_ready);
      else pass_cnt++;
      next_cycle();
    end
    hold = 1'b0;
    #1;
    total_cnt++;
    if (req_ready !== 2'b10)
      $display("FAIL hold_release got %b want 10", req_ready);
    else pass_cnt++;
    next_cycle();
    #1;
    total_cnt++;
    if (req_ready !== 2'b01)
      $display("FAIL hold_after got %b want 01", req_ready);
    else pass_cnt++;
    next_cycle();
    req_valid = 2'b00;
    for (int k = 0; k < 4; k++) next_cycle();
  endtask

  initial begin
    rst = 1'b1; hold = 1'b0; req_valid = 2'b00;
    req_addr0 = '0; req_addr1 = '0; req_start0 = '0; req_start1 = '0;
    req_orient0 = '0; req_orient1 = '0; req_color0 = '0; req_color1 = '0;
    #1;
    test_reset();
    test_p0_bike();
    test_p1_crash();
    test_miss();
    test_corner_hit();
    test_back_to_back();
    test_reset_flight();
    test_hold();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
